// File: rtl/cache_axi_pkg.sv
// Shared types and AXI constants for the cache refill read arbiter.
package cache_axi_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RET} ArbStateType;

    typedef enum logic {OWN_IC, OWN_DC} OwnerType;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam int         LINE_BYTES_LOG2 = 4;

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// Cache-side refill ports for both caches plus the shared AXI4 AR/R channel.
interface cache_axi_rd_arbiter_if #(
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                           ic_rd_req;
    logic [ADDR_W-1:0]              ic_rd_addr;
    logic                           ic_rd_rdy;
    logic                           ic_ret_valid;
    logic [32*WORDS_PER_LINE-1:0]   ic_ret_data;

    logic                           dc_rd_req;
    logic [ADDR_W-1:0]              dc_rd_addr;
    logic                           dc_rd_rdy;
    logic                           dc_ret_valid;
    logic [32*WORDS_PER_LINE-1:0]   dc_ret_data;

    logic [3:0]                     arid;
    logic [ADDR_W-1:0]              araddr;
    logic [7:0]                     arlen;
    logic [2:0]                     arsize;
    logic [1:0]                     arburst;
    logic                           arvalid;
    logic                           arready;
    logic [3:0]                     rid;
    logic [31:0]                    rdata;
    logic [1:0]                     rresp;
    logic                           rlast;
    logic                           rvalid;
    logic                           rready;

    // The arbiter is the master: it owns the AXI request side and the cache replies.
    modport master (
        input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
        output ic_rd_rdy, ic_ret_valid, ic_ret_data,
        output dc_rd_rdy, dc_ret_valid, dc_ret_data,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_data,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/cache_axi_rd_arbiter_rd_line_assembler.sv
// Collects R beats into one cache line; the beat index saturates on the last word.
module rd_line_assembler #(
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         beat_en,
    input  logic                         clr,
    input  logic [31:0]                  rdata,
    output logic [32*WORDS_PER_LINE-1:0] line
);

    localparam int                BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    logic [BEAT_W-1:0]                 beat;
    logic [WORDS_PER_LINE-1:0][31:0]   buffer;

    // clr only rewinds the index, so a short burst leaves older words in place.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat   <= '0;
            buffer <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (beat_en) begin
            buffer[beat] <= rdata;
            if (beat != LAST_BEAT) begin
                beat <= beat + 1'b1;
            end
        end
    end

    assign line = buffer;

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read channel between ICache and DCache line refills.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is fixed DCache priority.
module cache_axi_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int         WORDS_PER_LINE = 4,
    parameter int         ADDR_W         = 32,
    parameter logic [3:0] IC_ID          = 4'd0,
    parameter logic [3:0] DC_ID          = 4'd1
) (
    input  logic                   clk,
    input  logic                   resetn,
    cache_axi_rd_arbiter_if.master bus
);

    ArbStateType                  state;
    ArbStateType                  next_state;
    OwnerType                     owner;
    logic [ADDR_W-1:0]            araddr_q;
    logic                         grant_ic;
    logic                         grant_dc;
    logic                         accept;
    logic [ADDR_W-1:0]            sel_addr;
    logic                         beat_en;
    logic                         clr;
    logic [32*WORDS_PER_LINE-1:0] line;
    logic                         unused_ok;

`ifdef ARB_ROUND_ROBIN_EN
    OwnerType last_owner;
`endif

    // Grants are only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (resetn && state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.ic_rd_req && bus.dc_rd_req) begin
                grant_dc = (last_owner == OWN_IC);
                grant_ic = (last_owner == OWN_DC);
            end else begin
                grant_ic = bus.ic_rd_req;
                grant_dc = bus.dc_rd_req;
            end
`else
            grant_dc = bus.dc_rd_req;
            grant_ic = bus.ic_rd_req && !bus.dc_rd_req;
`endif
        end
    end

    assign accept   = grant_ic || grant_dc;
    assign sel_addr = grant_dc ? bus.dc_rd_addr : bus.ic_rd_addr;

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        beat_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = ADDR;
                    clr        = 1'b1;
                end
            end
            ADDR: begin
                if (bus.arready) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bus.rvalid) begin
                    beat_en = 1'b1;
                    if (bus.rlast) begin
                        next_state = RET;
                    end
                end
            end
            RET:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            owner    <= OWN_IC;
            araddr_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                owner    <= grant_dc ? OWN_DC : OWN_IC;
                araddr_q <= {sel_addr[ADDR_W-1:LINE_BYTES_LOG2], {LINE_BYTES_LOG2{1'b0}}};
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_owner <= OWN_IC;
        end else if (accept) begin
            last_owner <= grant_dc ? OWN_DC : OWN_IC;
        end
    end
`endif

    rd_line_assembler #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_assembler (
        .clk     (clk),
        .resetn  (resetn),
        .beat_en (beat_en),
        .clr     (clr),
        .rdata   (bus.rdata),
        .line    (line)
    );

    // AR payload is zeroed outside ADDR so every output reads 0 straight after reset.
    assign bus.arvalid      = (state == ADDR);
    assign bus.araddr       = bus.arvalid ? araddr_q : '0;
    assign bus.arid         = bus.arvalid ? ((owner == OWN_DC) ? DC_ID : IC_ID) : 4'd0;
    assign bus.arlen        = bus.arvalid ? 8'(WORDS_PER_LINE - 1) : 8'd0;
    assign bus.arsize       = bus.arvalid ? AXI_SIZE_4B : 3'd0;
    assign bus.arburst      = bus.arvalid ? AXI_BURST_INCR : 2'd0;
    assign bus.rready       = (state == DATA);

    assign bus.ic_rd_rdy    = grant_ic;
    assign bus.dc_rd_rdy    = grant_dc;
    assign bus.ic_ret_valid = (state == RET) && (owner == OWN_IC);
    assign bus.dc_ret_valid = (state == RET) && (owner == OWN_DC);
    assign bus.ic_ret_data  = line;
    assign bus.dc_ret_data  = line;

    assign unused_ok = ^{bus.rid, bus.rresp, sel_addr[LINE_BYTES_LOG2-1:0]};

endmodule
